sbus_mem_ctl: RTL and testbench
===============================

// Module: sbus_mem_ctl
//
// PURPOSE
//   Memory-side SBUS controller that sits directly downstream of the MBOX.
//   Accepts quadword read/write requests that the MBOX issues on the SBUS,
//   acknowledges them, and services the requested words from a local
//   core-memory array. Reads return one word per DATA_VALID strobe; writes
//   consume one word per WR_DATA_VALID strobe. Nonexistent memory (NXM) and
//   malformed requests are reported on ERR.
//
// PARAMETERS
//   ADDR_BITS    14  word-address bits implemented; array depth is 2**ADDR_BITS words
//   ACK_DELAY     2  cycles from accepted START to the ACKN pulse (min 1)
//   ACCESS_DELAY  4  cycles from ACKN to the first data slot (min 1)
//
// PORTS
//   mboxClk        in   1      single clock, all state changes on its rising edge
//   CROBAR         in   1      reset, synchronous, active-high
//   START          in   1      request strobe; sampled only in IDLE
//   RD_RQ          in   1      read request qualifier
//   WR_RQ          in   1      write request qualifier
//   ADR            in   [14:35] word address; ADR[34:35] selects the first word of the quadword
//   RQ             in   [0:3]  word-enable mask; RQ[n] enables word n of the quadword
//   D_IN           in   [0:35] write data
//   WR_DATA_VALID  in   1      D_IN holds the current write word
//   ACKN           out  1      one-cycle request acknowledge
//   DATA_VALID     out  1      one-cycle strobe; D_OUT holds a read word
//   D_OUT          out  [0:35] read data; zero when DATA_VALID=0
//   ERR            out  1      one-cycle error pulse (malformed request or NXM)
//   BUSY           out  1      high in every state except IDLE
//
// BEHAVIOUR
//   - Reset: FSM=IDLE; ACKN, DATA_VALID, ERR and BUSY are 0; D_OUT=0. Array contents are NOT cleared.
//   - States: IDLE -> ACKW -> ACCESS -> XFER -> IDLE.
//   - IDLE + START:
//       * Malformed (RD_RQ==WR_RQ, or RQ==0): ERR=1 on the next cycle; stay in IDLE.
//       * Otherwise latch ADR, RQ, op and slot=ADR[34:35]; go to ACKW with counter=ACK_DELAY.
//   - ACKW: decrement the counter; at 1:
//       * Address in range (ADR bits above ADDR_BITS all 0): ACKN=1 that cycle; go to ACCESS with counter=ACCESS_DELAY.
//       * NXM: no ACKN; ERR=1 that cycle; go to IDLE.
//   - ACCESS: decrement the counter; at 1, go to XFER.
//   - XFER visits four slots in order slot, slot+1, ... mod 4; the wrap stays inside the quadword.
//       * A slot with RQ[slot]=0 is skipped in 1 cycle with no strobe.
//       * Read slot: DATA_VALID=1 and D_OUT=mem[{ADR[14:33],slot}] for exactly 1 cycle.
//       * Write slot: wait, with no timeout, until WR_DATA_VALID=1; write D_IN that cycle; advance the next cycle.
//       * After the 4th slot: go to IDLE; BUSY falls on the cycle IDLE is entered.
//   - Hazards:
//       * WR_DATA_VALID outside a write slot of XFER is ignored.
//       * START while BUSY is ignored and is not queued.
//       * START in the same cycle as the return to IDLE is ignored; it is sampled from the next cycle on.
//   - Timing: read latency from START to the first DATA_VALID = ACK_DELAY+ACCESS_DELAY+1 cycles, given RQ[ADR[34:35]]=1.
//   - CROBAR mid-operation: the next state is IDLE and all outputs are 0; partially written quadwords keep the words already written.
//   - Bit numbering is PDP-10 big-endian: bit 0 is the MSB.
//
// TESTING
//   1. Write 0o123456654321 to 0o100 (RQ=1000, ADR[34:35]=0), then read it back -> ACKN at +2 cycles, one DATA_VALID at +7 with matching data.
//   2. Read at ADR=...10 with RQ=1111 -> DATA_VALID carries words 2,3,0,1 in that order on 4 consecutive cycles.
//   3. Read with RQ=0101, start slot 0 -> strobes for words 1 and 3 only, with a 1-cycle gap between them.
//   4. START with RD_RQ=WR_RQ=1 -> ERR on the next cycle, no ACKN, BUSY stays 0.
//   5. ADR with a bit above ADDR_BITS set -> ERR at +2 cycles, no ACKN, FSM back in IDLE.
//   6. Write stalled by WR_DATA_VALID=0 for 10 cycles, then CROBAR -> IDLE, outputs 0; a later read shows the earlier words intact.

Source files
------------

// File: rtl/sbus_mem_ctl.sv
// Memory-side SBUS controller: acknowledges MBOX quadword requests and services
// the enabled words of each quadword from a local core-memory array.
module sbus_mem_ctl #(
  parameter int ADDR_BITS    = 14,
  parameter int ACK_DELAY    = 2,
  parameter int ACCESS_DELAY = 4
) (
  input  logic         mboxClk,
  input  logic         CROBAR,
  input  logic         START,
  input  logic         RD_RQ,
  input  logic         WR_RQ,
  input  logic [14:35] ADR,
  input  logic [0:3]   RQ,
  input  logic [0:35]  D_IN,
  input  logic         WR_DATA_VALID,
  output logic         ACKN,
  output logic         DATA_VALID,
  output logic [0:35]  D_OUT,
  output logic         ERR,
  output logic         BUSY
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACKW   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_XFER   = 2'd3;

  localparam int         DEPTH    = 2 ** ADDR_BITS;
  localparam logic [7:0] ACK_INIT = 8'(ACK_DELAY);
  localparam logic [7:0] ACC_INIT = 8'(ACCESS_DELAY);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [21:0] adr_q, adr_d;
  logic [0:3]  rq_q, rq_d;
  logic        rd_q, rd_d;
  logic [1:0]  slot_q, slot_d;
  logic [1:0]  vis_q, vis_d;
  logic        ret_q, ret_d;
  logic        ackn_q, ackn_d;
  logic        dv_q, dv_d;
  logic [35:0] dout_q, dout_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        malformed_s;
  logic        wr_en_s;
  logic [35:0] mem_q [0:DEPTH-1];

  function automatic logic addr_in_range(input logic [21:0] a);
    return (a >> ADDR_BITS) == 22'd0;
  endfunction

  // Quadword base from the latched address, word within it from the slot.
  function automatic logic [ADDR_BITS-1:0] word_idx(input logic [21:0] a, input logic [1:0] s);
    logic [21:0] t;
    t = {a[21:2], s};
    return t[ADDR_BITS-1:0];
  endfunction

  // Next-state logic for the request FSM and quadword walk.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    adr_d       = adr_q;
    rq_d        = rq_q;
    rd_d        = rd_q;
    slot_d      = slot_q;
    vis_d       = vis_q;
    malformed_s = 1'b0;
    wr_en_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The first IDLE cycle after a transaction never samples START.
        if (START && !ret_q) begin
          if ((RD_RQ == WR_RQ) || (RQ == 4'b0000)) begin
            malformed_s = 1'b1;
          end else begin
            state_d = S_ACKW;
            cnt_d   = ACK_INIT;
            adr_d   = ADR;
            rq_d    = RQ;
            rd_d    = RD_RQ;
            slot_d  = ADR[34:35];
            vis_d   = 2'd0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACKW: begin
        if (cnt_q == 8'd1) begin
          if (addr_in_range(adr_q)) begin
            state_d = S_ACCESS;
            cnt_d   = ACC_INIT;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 8'd1) begin
          state_d = S_XFER;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_XFER: begin
        if (!rq_q[slot_q] || rd_q || WR_DATA_VALID) begin
          wr_en_s = !rd_q && rq_q[slot_q] && WR_DATA_VALID && !CROBAR;
          if (vis_q == 2'd3) begin
            state_d = S_IDLE;
          end else begin
            slot_d = slot_q + 2'd1;
            vis_d  = vis_q + 2'd1;
          end
        end else begin
          state_d = S_XFER;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered, so they are derived from the state being entered.
  always_comb begin
    ackn_d = (state_d == S_ACKW) && (cnt_d == 8'd1) && addr_in_range(adr_d);
    err_d  = malformed_s || ((state_d == S_ACKW) && (cnt_d == 8'd1) && !addr_in_range(adr_d));
    dv_d   = (state_d == S_XFER) && rd_d && rq_d[slot_d];
    busy_d = (state_d != S_IDLE);
    ret_d  = (state_q != S_IDLE) && (state_d == S_IDLE);
    if (dv_d) begin
      dout_d = mem_q[word_idx(adr_d, slot_d)];
    end else begin
      dout_d = 36'd0;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge mboxClk) begin
    if (CROBAR) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      adr_q   <= 22'd0;
      rq_q    <= 4'b0000;
      rd_q    <= 1'b0;
      slot_q  <= 2'd0;
      vis_q   <= 2'd0;
      ret_q   <= 1'b0;
      ackn_q  <= 1'b0;
      dv_q    <= 1'b0;
      dout_q  <= 36'd0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      rq_q    <= rq_d;
      rd_q    <= rd_d;
      slot_q  <= slot_d;
      vis_q   <= vis_d;
      ret_q   <= ret_d;
      ackn_q  <= ackn_d;
      dv_q    <= dv_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Core array is never cleared; reset only blocks the write.
  always_ff @(posedge mboxClk) begin
    if (wr_en_s) begin
      mem_q[word_idx(adr_q, slot_q)] <= D_IN;
    end
  end

  assign ACKN       = ackn_q;
  assign DATA_VALID = dv_q;
  assign D_OUT      = dout_q;
  assign ERR        = err_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_sbus_mem_ctl.sv
// Self-checking bench for sbus_mem_ctl: directed scenarios plus randomized
// quadword traffic checked cycle-by-cycle against a timeline model.
module tb_sbus_mem_ctl;

  localparam int ACK_D = 2;
  localparam int ACC_D = 4;
  localparam int XFER0 = ACK_D + ACC_D + 1;

  logic         clk = 1'b0;
  logic         crobar = 1'b1;
  logic         start = 1'b0;
  logic         rd_rq = 1'b0;
  logic         wr_rq = 1'b0;
  logic [14:35] adr_s = '0;
  logic [0:3]   rq_s = '0;
  logic [0:35]  din = '0;
  logic         wdv = 1'b0;
  logic         ackn, dv, err, busy;
  logic [0:35]  dout;

  int n_tests = 0;
  int n_fail  = 0;

  logic [35:0] mm [int];
  logic        e_ack [256], e_err [256], e_dv [256], e_busy [256], e_chk [256];
  logic [35:0] e_dout [256];
  logic        o_ack [256], o_err [256], o_dv [256], o_busy [256];
  logic [35:0] o_dout [256];
  int          wcyc [4];
  logic [35:0] wdat [4];
  int          gap [4];
  logic [35:0] q_words [4];

  sbus_mem_ctl #(.ADDR_BITS(14), .ACK_DELAY(ACK_D), .ACCESS_DELAY(ACC_D)) dut (
    .mboxClk(clk), .CROBAR(crobar), .START(start), .RD_RQ(rd_rq), .WR_RQ(wr_rq),
    .ADR(adr_s), .RQ(rq_s), .D_IN(din), .WR_DATA_VALID(wdv),
    .ACKN(ackn), .DATA_VALID(dv), .D_OUT(dout), .ERR(err), .BUSY(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  function automatic logic [35:0] rand36();
    return {4'($urandom_range(0, 15)), 32'($urandom)};
  endfunction

  // Expected per-cycle outputs of one request, laid out on a timeline.
  task automatic build_expect(input bit rd, input bit wr, input logic [21:0] a,
                              input logic [0:3] rq, output int ncyc);
    int t, s, idx;
    for (int i = 0; i < 256; i++) begin
      e_ack[i] = 0; e_err[i] = 0; e_dv[i] = 0; e_busy[i] = 0; e_chk[i] = 1; e_dout[i] = 36'd0;
    end
    for (int k = 0; k < 4; k++) wcyc[k] = -1;
    if (rd == wr || rq == 4'b0000) begin
      e_err[1] = 1;
      ncyc = 1;
    end else if ((a >> 14) != 22'd0) begin
      for (int c = 1; c <= ACK_D; c++) e_busy[c] = 1;
      e_err[ACK_D] = 1;
      ncyc = ACK_D + 2;
    end else begin
      e_ack[ACK_D] = 1;
      t = XFER0;
      for (int i = 0; i < 4; i++) begin
        s = (int'(a[1:0]) + i) % 4;
        idx = (int'(a) / 4) * 4 + s;
        if (!rq[s]) begin
          t = t + 1;
        end else if (rd) begin
          e_dv[t] = 1;
          e_chk[t] = mm.exists(idx);
          e_dout[t] = mm.exists(idx) ? mm[idx] : 36'd0;
          t = t + 1;
        end else begin
          t = t + gap[i];
          wcyc[s] = t;
          mm[idx] = wdat[s];
          t = t + 1;
        end
      end
      for (int c = 1; c < t; c++) e_busy[c] = 1;
      ncyc = t + 1;
    end
  endtask

  // Drives one request (cycle 0) and records outputs of cycles 1..ncyc.
  task automatic do_txn(input bit rd, input bit wr, input logic [21:0] a, input logic [0:3] rq,
                        input int ncyc, input int hazard, input int crobar_cyc);
    for (int c = 0; c < ncyc; c++) begin
      if (c == 0) begin
        start = 1; rd_rq = rd; wr_rq = wr; adr_s = a; rq_s = rq;
      end else if (hazard == 2 || (hazard == 1 && $urandom_range(0, 3) == 0)) begin
        start = 1; rd_rq = 1; wr_rq = 0; adr_s = 22'($urandom_range(0, 16383)); rq_s = 4'b1111;
      end else begin
        start = 0; rd_rq = 1'($urandom); wr_rq = 1'($urandom);
      end
      wdv = 0;
      din = rand36();
      for (int k = 0; k < 4; k++) begin
        if (wcyc[k] == c) begin
          wdv = 1; din = wdat[k];
        end
      end
      if (!wdv && hazard != 0 && (rd || c < XFER0)) wdv = (hazard == 2) ? 1'b1 : 1'($urandom);
      crobar = (c == crobar_cyc);
      @(posedge clk); #1;
      o_ack[c+1] = ackn; o_err[c+1] = err; o_dv[c+1] = dv; o_busy[c+1] = busy; o_dout[c+1] = dout;
    end
    start = 0; wdv = 0; crobar = 0;
  endtask

  task automatic idle(input int n);
    start = 0; wdv = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    crobar = 1;
    idle(2);
    n_tests++; if (ackn !== 1'b0) begin n_fail++; $display("FAIL reset_ackn got %b want 0", ackn); end
    n_tests++; if (dv !== 1'b0) begin n_fail++; $display("FAIL reset_dv got %b want 0", dv); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (dout !== 36'd0) begin n_fail++; $display("FAIL reset_dout got %o want 0", dout); end
    crobar = 0;
    idle(1);
  endtask

  task automatic test_write_read();
    int n, ndv;
    for (int k = 0; k < 4; k++) gap[k] = 0;
    wdat[0] = 36'o123456654321;
    build_expect(0, 1, 22'o100, 4'b1000, n);
    do_txn(0, 1, 22'o100, 4'b1000, n, 0, -1);
    n_tests++; if (o_ack[2] !== 1'b1) begin n_fail++; $display("FAIL wr_ack2 got %b want 1", o_ack[2]); end
    build_expect(1, 0, 22'o100, 4'b1000, n);
    do_txn(1, 0, 22'o100, 4'b1000, n, 0, -1);
    n_tests++; if (o_ack[2] !== 1'b1) begin n_fail++; $display("FAIL rd_ack2 got %b want 1", o_ack[2]); end
    n_tests++; if (o_dv[7] !== 1'b1) begin n_fail++; $display("FAIL rd_dv7 got %b want 1", o_dv[7]); end
    n_tests++; if (o_dout[7] !== 36'o123456654321) begin n_fail++; $display("FAIL rd_data got %o want 123456654321", o_dout[7]); end
    ndv = 0;
    for (int c = 1; c <= n; c++) ndv += int'(o_dv[c]);
    n_tests++; if (ndv != 1) begin n_fail++; $display("FAIL rd_dv_count got %0d want 1", ndv); end
  endtask

  task automatic test_wrap_read();
    int n;
    logic [35:0] want [4];
    for (int k = 0; k < 4; k++) begin gap[k] = k; q_words[k] = rand36(); wdat[k] = q_words[k]; end
    build_expect(0, 1, 22'o200, 4'b1111, n);
    do_txn(0, 1, 22'o200, 4'b1111, n, 0, -1);
    build_expect(1, 0, 22'o202, 4'b1111, n);
    do_txn(1, 0, 22'o202, 4'b1111, n, 0, -1);
    want[0] = q_words[2]; want[1] = q_words[3]; want[2] = q_words[0]; want[3] = q_words[1];
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (o_dv[7+i] !== 1'b1) begin n_fail++; $display("FAIL wrap_dv cyc %0d got %b want 1", 7+i, o_dv[7+i]); end
      n_tests++; if (o_dout[7+i] !== want[i]) begin n_fail++; $display("FAIL wrap_data cyc %0d got %o want %o", 7+i, o_dout[7+i], want[i]); end
    end
    n_tests++; if (o_busy[10] !== 1'b1 || o_busy[11] !== 1'b0) begin n_fail++; $display("FAIL wrap_busy got %b%b want 10", o_busy[10], o_busy[11]); end
  endtask

  task automatic test_sparse_read();
    int n;
    logic exp_dv;
    build_expect(1, 0, 22'o200, 4'b0101, n);
    do_txn(1, 0, 22'o200, 4'b0101, n, 0, -1);
    for (int c = 6; c <= 11; c++) begin
      exp_dv = (c == 8 || c == 10);
      n_tests++; if (o_dv[c] !== exp_dv) begin n_fail++; $display("FAIL sparse_dv cyc %0d got %b want %b", c, o_dv[c], exp_dv); end
    end
    n_tests++; if (o_dout[8] !== q_words[1]) begin n_fail++; $display("FAIL sparse_w1 got %o want %o", o_dout[8], q_words[1]); end
    n_tests++; if (o_dout[10] !== q_words[3]) begin n_fail++; $display("FAIL sparse_w3 got %o want %o", o_dout[10], q_words[3]); end
    n_tests++; if (o_dout[9] !== 36'd0) begin n_fail++; $display("FAIL sparse_gap_dout got %o want 0", o_dout[9]); end
  endtask

  task automatic test_malformed();
    int n;
    bit rd, wr;
    logic [0:3] rq;
    for (int k = 0; k < 3; k++) begin
      rd = (k != 1); wr = (k == 0); rq = (k == 2) ? 4'b0000 : 4'b1111;
      build_expect(rd, wr, 22'o300, rq, n);
      do_txn(rd, wr, 22'o300, rq, 4, 0, -1);
      n_tests++; if (o_err[1] !== 1'b1) begin n_fail++; $display("FAIL malf_err case %0d got %b want 1", k, o_err[1]); end
      for (int c = 1; c <= 4; c++) begin
        n_tests++;
        if (o_ack[c] !== 1'b0 || o_busy[c] !== 1'b0) begin
          n_fail++; $display("FAIL malf_ack_busy case %0d cyc %0d got %b%b want 00", k, c, o_ack[c], o_busy[c]);
        end
      end
    end
  endtask

  task automatic test_nxm();
    int n;
    build_expect(1, 0, 22'h200000 | 22'o300, 4'b1111, n);
    do_txn(1, 0, 22'h200000 | 22'o300, 4'b1111, n, 0, -1);
    n_tests++; if (o_err[2] !== 1'b1) begin n_fail++; $display("FAIL nxm_err got %b want 1", o_err[2]); end
    n_tests++; if (o_ack[1] !== 1'b0 || o_ack[2] !== 1'b0) begin n_fail++; $display("FAIL nxm_ack got %b%b want 00", o_ack[1], o_ack[2]); end
    n_tests++; if (o_busy[1] !== 1'b1 || o_busy[3] !== 1'b0) begin n_fail++; $display("FAIL nxm_busy got %b%b want 10", o_busy[1], o_busy[3]); end
    build_expect(1, 0, 22'o200, 4'b1000, n);
    do_txn(1, 0, 22'o200, 4'b1000, n, 0, -1);
    n_tests++; if (o_dv[7] !== 1'b1 || o_dout[7] !== q_words[0]) begin n_fail++; $display("FAIL nxm_after_read got %b %o want 1 %o", o_dv[7], o_dout[7], q_words[0]); end
  endtask

  task automatic test_crobar_stall();
    int n;
    logic [35:0] want [4];
    for (int k = 0; k < 4; k++) wcyc[k] = -1;
    wdat[0] = rand36(); wdat[1] = rand36();
    wcyc[0] = XFER0; wcyc[1] = XFER0 + 1;
    do_txn(0, 1, 22'o200, 4'b1111, 20, 0, 19);
    n_tests++; if (o_busy[19] !== 1'b1) begin n_fail++; $display("FAIL crobar_stall_busy got %b want 1", o_busy[19]); end
    n_tests++;
    if ({o_ack[20], o_dv[20], o_err[20], o_busy[20]} !== 4'b0000 || o_dout[20] !== 36'd0) begin
      n_fail++; $display("FAIL crobar_outputs got %b%b%b%b %o want 0000 0", o_ack[20], o_dv[20], o_err[20], o_busy[20], o_dout[20]);
    end
    q_words[0] = wdat[0]; q_words[1] = wdat[1];
    for (int k = 0; k < 4; k++) mm[128 + k] = q_words[k];
    idle(2);
    want[0] = q_words[0]; want[1] = q_words[1]; want[2] = q_words[2]; want[3] = q_words[3];
    build_expect(1, 0, 22'o200, 4'b1111, n);
    do_txn(1, 0, 22'o200, 4'b1111, n, 0, -1);
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (o_dv[7+i] !== 1'b1 || o_dout[7+i] !== want[i]) begin n_fail++; $display("FAIL crobar_readback word %0d got %b %o want 1 %o", i, o_dv[7+i], o_dout[7+i], want[i]); end
    end
  endtask

  task automatic test_start_hazard();
    int n;
    build_expect(1, 0, 22'o200, 4'b1111, n);
    do_txn(1, 0, 22'o200, 4'b1111, n, 2, -1);
    for (int c = 1; c <= n; c++) begin
      n_tests++;
      if (o_ack[c] !== e_ack[c] || o_err[c] !== e_err[c] || o_dv[c] !== e_dv[c] || o_busy[c] !== e_busy[c] || o_dout[c] !== e_dout[c]) begin
        n_fail++; $display("FAIL hazard cyc %0d got a%b e%b v%b b%b %o want a%b e%b v%b b%b %o", c,
          o_ack[c], o_err[c], o_dv[c], o_busy[c], o_dout[c], e_ack[c], e_err[c], e_dv[c], e_busy[c], e_dout[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n, kind, bases [4];
    bit rd, wr;
    logic [21:0] a;
    logic [0:3] rq;
    for (int b = 0; b < 4; b++) bases[b] = $urandom_range(0, 4095) * 4;
    for (int i = 0; i < 44; i++) begin
      for (int k = 0; k < 4; k++) begin gap[k] = $urandom_range(0, 3); wdat[k] = rand36(); end
      kind = (i < 4) ? 9 : $urandom_range(0, 9);
      a = 22'(bases[(i < 4) ? i : $urandom_range(0, 3)]) | 22'($urandom_range(0, 3));
      if (i < 4) begin
        rd = 0; wr = 1; rq = 4'b1111;
      end else if (kind == 0) begin
        rd = 1'($urandom); wr = ($urandom_range(0, 1) == 0) ? rd : 1'b0; rq = (wr == rd) ? 4'($urandom_range(1, 15)) : 4'b0000; rd = (wr == rd) ? rd : 1'b1;
      end else if (kind == 1) begin
        rd = 1'($urandom); wr = !rd; rq = 4'($urandom_range(1, 15)); a = a | (22'd1 << $urandom_range(14, 21));
      end else begin
        rd = 1'($urandom); wr = !rd; rq = 4'($urandom_range(1, 15));
      end
      build_expect(rd, wr, a, rq, n);
      do_txn(rd, wr, a, rq, n, 1, -1);
      for (int c = 1; c <= n; c++) begin
        n_tests++;
        if (o_ack[c] !== e_ack[c] || o_err[c] !== e_err[c] || o_dv[c] !== e_dv[c] || o_busy[c] !== e_busy[c] ||
            ((e_chk[c] || !e_dv[c]) && o_dout[c] !== e_dout[c])) begin
          n_fail++; $display("FAIL rnd txn %0d cyc %0d got a%b e%b v%b b%b %o want a%b e%b v%b b%b %o", i, c,
            o_ack[c], o_err[c], o_dv[c], o_busy[c], o_dout[c], e_ack[c], e_err[c], e_dv[c], e_busy[c], e_dout[c]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wrap_read();
    test_sparse_read();
    test_malformed();
    test_nxm();
    test_crobar_stall();
    test_start_hazard();
    test_back_to_back();
    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
